// File: rtl/core_run_monitor.sv
// core_run_monitor: run sequencer and PC/instruction trace monitor
// for the single-cycle MIPS core.
module core_run_monitor #(
    parameter int          DATA_W      = 32,
    parameter int          TRACE_DEPTH = 16,
    parameter int          RST_HOLD    = 4,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int          HALT_REPEAT = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            pc,
    input  logic [DATA_W-1:0]            instruction,
    output logic                         core_reset,
    output logic                         running,
    output logic                         done,
    output logic                         halted,
    output logic                         timeout,
    output logic [31:0]                  cycle_count,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [DATA_W-1:0]            trace_pc,
    output logic [DATA_W-1:0]            trace_instr,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              clear;
    logic [HW-1:0]     hold_cnt;
    logic [RW-1:0]     rep_cnt;
    logic [RW-1:0]     rep_next;
    logic [DATA_W-1:0] prev_pc;
    logic              have_prev;
    logic [31:0]       cnt_next;
    logic              hit_halt;
    logic              hit_time;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] pc_mem    [TRACE_DEPTH];
    logic [DATA_W-1:0] instr_mem [TRACE_DEPTH];
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;

    assign core_reset = (state != S_RUN);
    assign running    = (state == S_RUN);
    assign done       = (state == S_DONE);

    assign cnt_next = cycle_count + 32'd1;
    assign hit_time = (cnt_next == 32'(MAX_CYCLES));
    assign hit_halt = (rep_next == RW'(HALT_REPEAT));

    // First RUN cycle has no previous PC, so it can never count as a repeat.
    always_comb begin
        rep_next = '0;
        if (have_prev && (pc == prev_pc))
            rep_next = rep_cnt + RW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RESET;
                    clear      = 1'b1;
                end
            end
            S_RESET: begin
                if (hold_cnt == HW'(RST_HOLD - 1))
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (hit_halt || hit_time)
                    state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            prev_pc     <= '0;
            have_prev   <= 1'b0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else if (clear) begin
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            prev_pc     <= '0;
            have_prev   <= 1'b0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (state == S_RESET)
                hold_cnt <= hold_cnt + HW'(1);
            if (state == S_RUN) begin
                cycle_count <= cnt_next;
                rep_cnt     <= rep_next;
                prev_pc     <= pc;
                have_prev   <= 1'b1;
                if (hit_halt)
                    halted <= 1'b1;
                if (hit_time)
                    timeout <= 1'b1;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push        = (state == S_RUN);
    assign full        = (trace_count == CW'(TRACE_DEPTH));
    assign trace_valid = (trace_count != '0);
    assign pop         = trace_valid & trace_ready;
    assign do_push     = push & (~full | pop);
    assign drop        = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)
                trace_count <= trace_count + CW'(1);
            else if (pop && !do_push)
                trace_count <= trace_count - CW'(1);
            if (drop)
                trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= instruction;
        end
    end

    // Storage is not reset; an empty FIFO presents zeros at the head.
    assign trace_pc    = trace_valid ? pc_mem[rd_ptr] : '0;
    assign trace_instr = trace_valid ? instr_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_core_run_monitor.sv
// Testbench for core_run_monitor: directed steps plus randomized runs
// checked against a queue-based reference model.
module tb_core_run_monitor;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int HOLD  = 4;
    localparam int MAXC  = 20;
    localparam int HREP  = 3;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    localparam int P_IDLE  = 0;
    localparam int P_RESET = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic            clk;
    logic            reset;
    logic            start;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   instruction;
    logic            trace_ready;
    logic            core_reset;
    logic            running;
    logic            done;
    logic            halted;
    logic            timeout;
    logic [31:0]     cycle_count;
    logic            trace_valid;
    logic [DW-1:0]   trace_pc;
    logic [DW-1:0]   trace_instr;
    logic [CNTW-1:0] trace_count;
    logic            trace_overflow;

    int checks = 0;
    int errors = 0;

    int              m_phase;
    int              m_hold_left;
    int              m_cycles;
    bit              m_halted;
    bit              m_timeout;
    bit              m_ovf;
    logic [2*DW-1:0] m_q[$];
    logic [DW-1:0]   m_pcs[$];

    core_run_monitor #(
        .DATA_W(DW), .TRACE_DEPTH(DEPTH), .RST_HOLD(HOLD),
        .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pc(pc), .instruction(instruction),
        .core_reset(core_reset), .running(running), .done(done),
        .halted(halted), .timeout(timeout), .cycle_count(cycle_count),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_hold_left = 0;
        m_cycles    = 0;
        m_halted    = 0;
        m_timeout   = 0;
        m_ovf       = 0;
        m_q.delete();
        m_pcs.delete();
    endtask

    // Length of the run of identical PCs at the end of this run's history.
    function automatic int trailing_same();
        int n = 1;
        for (int i = m_pcs.size() - 1; i > 0; i--) begin
            if (m_pcs[i] == m_pcs[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_edge();
        bit pop;
        if (!reset) begin
            model_reset();
            return;
        end
        pop = (m_q.size() != 0) && trace_ready;
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (start) begin
                    model_reset();
                    m_phase     = P_RESET;
                    m_hold_left = HOLD;
                end else if (pop) begin
                    void'(m_q.pop_front());
                end
            end
            P_RESET: begin
                if (pop) void'(m_q.pop_front());
                m_hold_left--;
                if (m_hold_left == 0) m_phase = P_RUN;
            end
            default: begin
                if (pop) void'(m_q.pop_front());
                if (m_q.size() < DEPTH) m_q.push_back({pc, instruction});
                else m_ovf = 1;
                m_cycles++;
                m_pcs.push_back(pc);
                if (trailing_same() >= HREP + 1) m_halted = 1;
                if (m_cycles == MAXC) m_timeout = 1;
                if (m_halted || m_timeout) m_phase = P_DONE;
            end
        endcase
    endtask

    task automatic check_all(string tag);
        logic [2*DW-1:0] h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, "/core_reset"}, 64'(core_reset), 64'(m_phase != P_RUN));
        chk({tag, "/running"}, 64'(running), 64'(m_phase == P_RUN));
        chk({tag, "/done"}, 64'(done), 64'(m_phase == P_DONE));
        chk({tag, "/halted"}, 64'(halted), 64'(m_halted));
        chk({tag, "/timeout"}, 64'(timeout), 64'(m_timeout));
        chk({tag, "/cycle_count"}, 64'(cycle_count), 64'(m_cycles));
        chk({tag, "/trace_valid"}, 64'(trace_valid), 64'(m_q.size() != 0));
        chk({tag, "/trace_count"}, 64'(trace_count), 64'(m_q.size()));
        chk({tag, "/trace_overflow"}, 64'(trace_overflow), 64'(m_ovf));
        chk({tag, "/trace_pc"}, 64'(trace_pc), 64'(h[2*DW-1:DW]));
        chk({tag, "/trace_instr"}, 64'(trace_instr), 64'(h[DW-1:0]));
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_start(string tag);
        start = 1'b1;
        step(tag);
        start = 1'b0;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 20 && m_phase == P_RESET; k++)
            step("hold");
        chk("reached_run", 64'(running), 64'd1);
    endtask

    logic [DW-1:0] hseq [6];

    initial begin
        hseq = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
        reset       = 1'b1;
        start       = 1'b0;
        pc          = '0;
        instruction = '0;
        trace_ready = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        #1 check_all("por");

        // Reset held through edges 1..5, start sampled at edge 10.
        for (int i = 0; i < 5; i++) step("rst_hold");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("idle");
        do_start("start10");
        for (int i = 0; i < 3; i++) step("hold");
        chk("edge13_core_reset", 64'(core_reset), 64'd1);
        step("hold14");
        chk("edge14_running", 64'(running), 64'd1);
        chk("edge14_core_reset", 64'(core_reset), 64'd0);

        // Timeout run with stalled consumer.
        for (int k = 0; k < 200 && m_phase == P_RUN; k++) begin
            pc          = 32'(4 * k);
            instruction = $urandom;
            step("timeout_run");
        end
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_halted", 64'(halted), 64'd0);
        chk("to_cycles", 64'(cycle_count), 64'd20);
        chk("to_done", 64'(done), 64'd1);
        chk("to_count", 64'(trace_count), 64'd16);
        chk("to_overflow", 64'(trace_overflow), 64'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("to_drain_pc", 64'(trace_pc), 64'(4 * i));
            step("to_drain");
        end
        trace_ready = 1'b0;
        chk("to_drained", 64'(trace_valid), 64'd0);

        // Restart from DONE, then halt on repeated PC.
        do_start("restart");
        chk("restart_count", 64'(trace_count), 64'd0);
        chk("restart_timeout", 64'(timeout), 64'd0);
        chk("restart_ovf", 64'(trace_overflow), 64'd0);
        chk("restart_cycles", 64'(cycle_count), 64'd0);
        wait_run();
        for (int i = 0; i < 6; i++) begin
            pc          = hseq[i];
            instruction = $urandom;
            step("halt_run");
        end
        chk("h_halted", 64'(halted), 64'd1);
        chk("h_done", 64'(done), 64'd1);
        chk("h_timeout", 64'(timeout), 64'd0);
        chk("h_cycles", 64'(cycle_count), 64'd6);
        chk("h_count", 64'(trace_count), 64'd6);
        trace_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("h_drain_pc", 64'(trace_pc), 64'(hseq[i]));
            step("h_drain");
        end
        trace_ready = 1'b0;

        // Full FIFO with consumer ready: push and pop together.
        do_start("full_start");
        wait_run();
        for (int k = 0; k < 100 && m_phase == P_RUN; k++) begin
            pc          = 32'h100 + 32'(4 * k);
            instruction = $urandom;
            trace_ready = (k >= 16);
            start       = (k == 5);
            step("full_run");
        end
        start       = 1'b0;
        trace_ready = 1'b0;
        chk("full_count", 64'(trace_count), 64'd16);
        chk("full_ovf", 64'(trace_overflow), 64'd0);
        chk("full_cycles", 64'(cycle_count), 64'd20);
        chk("full_timeout", 64'(timeout), 64'd1);

        // Asynchronous reset between edges in the middle of a run.
        do_start("ar_start");
        wait_run();
        for (int k = 0; k < 5; k++) begin
            pc          = 32'h200 + 32'(4 * k);
            instruction = $urandom;
            step("ar_run");
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("ar_low");
        reset = 1'b1;
        step("ar_idle");
        do_start("ar_restart");
        wait_run();
        pc          = 32'h300;
        instruction = $urandom;
        step("ar_first");
        chk("ar_first_count", 64'(trace_count), 64'd1);
        chk("ar_first_cycles", 64'(cycle_count), 64'd1);
        for (int k = 0; k < 100 && m_phase == P_RUN; k++) begin
            pc          = 32'h304 + 32'(4 * k);
            instruction = $urandom;
            step("ar_run2");
        end

        // Randomized runs: small PC alphabet, random consumer and start.
        for (int r = 0; r < 6; r++) begin
            do_start("rnd_start");
            wait_run();
            for (int k = 0; k < 100 && m_phase == P_RUN; k++) begin
                pc          = 32'($urandom_range(0, 3) * 4);
                instruction = $urandom;
                trace_ready = 1'($urandom_range(0, 1));
                start       = ($urandom_range(0, 7) == 0);
                step("rnd_run");
            end
            start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                trace_ready = 1'($urandom_range(0, 1));
                step("rnd_done");
            end
        end
        chk("rnd_end_done", 64'(done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
